// File: rtl/pb_ctrl_pkg.sv
// pb_ctrl_pkg: shared FSM encoding, status-word field map and count width
//   for pushbutton_control_decoder and btn_debounce.
package pb_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } pb_state_e;

    localparam int COUNT_W       = 8;

    localparam int ST_STABLE_LSB = 0;
    localparam int ST_STABLE_MSB = 1;
    localparam int ST_HELD_LSB   = 2;
    localparam int ST_HELD_MSB   = 3;
    localparam int ST_RSVD_LSB   = 4;
    localparam int ST_RSVD_MSB   = 7;
    localparam int ST_SHORT0_LSB = 8;
    localparam int ST_SHORT0_MSB = 15;
    localparam int ST_SHORT1_LSB = 16;
    localparam int ST_SHORT1_MSB = 23;
    localparam int ST_LONG_LSB   = 24;
    localparam int ST_LONG_MSB   = 31;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: polarity fix, 2-FF synchronizer and debounce filter for one button.
//   clk, rstn : fabric clock, synchronous active-low reset
//   raw       : asynchronous button pin
//   stable    : debounced active-high level
module btn_debounce
    import pb_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 840000,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic meta, sync;
    logic [CW-1:0] cnt;

    // stable flips on the DEBOUNCE_CYCLES-th consecutive sample that disagrees with it
    always_ff @(posedge clk) begin
        if (!rstn) begin
            meta   <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            meta <= raw ^ ACTIVE_LOW;
            sync <= meta;
            if (sync == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= ~stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/pushbutton_control_decoder.sv
// pushbutton_control_decoder: debounced button press classification into control requests and a PS status word.
//   clk, rstn           : 84 MHz fabric clock, synchronous active-low reset
//   btn_raw             : asynchronous button pins
//   transmission_active : generator running flag, selects stop vs start
//   short_press         : one-cycle pulse per button on release of a short press
//   long_press          : one-cycle pulse per button when the long threshold is reached
//   ctrl_start/stop/reset : one-cycle generator requests from button 0
//   btn_status          : {long cnt, btn1 short cnt, btn0 short cnt, 4'b0, long-held flags, stable levels}
module pushbutton_control_decoder
    import pb_ctrl_pkg::*;
#(
    parameter int NUM_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES   = 840000,
    parameter int LONG_PRESS_CYCLES = 168000000,
    parameter bit BTN_ACTIVE_LOW    = 1'b0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    input  logic                   transmission_active,
    output logic [NUM_BUTTONS-1:0] short_press,
    output logic [NUM_BUTTONS-1:0] long_press,
    output logic                   ctrl_start,
    output logic                   ctrl_stop,
    output logic                   ctrl_reset,
    output logic [31:0]            btn_status
);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    // long fires on the cycle the hold counter would become LONG_PRESS_CYCLES-1
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 2);

    logic [NUM_BUTTONS-1:0] stable, held, short_evt, long_evt;
    logic [1:0] stable_w, held_w, short_w, long_w;
    logic [COUNT_W-1:0] short0_cnt, short1_cnt, long_cnt;
    logic [31:0] status_next;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        pb_state_e state;
        logic [HW-1:0] hold;

        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (BTN_ACTIVE_LOW)
        ) u_db (
            .clk   (clk),
            .rstn  (rstn),
            .raw   (btn_raw[i]),
            .stable(stable[i])
        );

        assign short_evt[i] = (state == PRESSED) && !stable[i];
        assign long_evt[i]  = (state == PRESSED) && stable[i] && (hold == HOLD_LAST);
        assign held[i]      = (state == LONG_HELD);

        always_ff @(posedge clk) begin
            if (!rstn) begin
                state <= IDLE;
                hold  <= '0;
            end else begin
                case (state)
                    IDLE: if (stable[i]) begin
                        state <= PRESSED;
                        hold  <= '0;
                    end
                    PRESSED: if (short_evt[i]) state <= IDLE;
                        else if (long_evt[i]) state <= LONG_HELD;
                        else hold <= hold + 1'b1;
                    LONG_HELD: if (!stable[i]) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // pad to two buttons so absent buttons read 0
    assign stable_w = 2'(stable);
    assign held_w   = 2'(held);
    assign short_w  = 2'(short_evt);
    assign long_w   = 2'(long_evt);

    always_comb begin
        status_next = '0;
        status_next[ST_STABLE_MSB:ST_STABLE_LSB] = stable_w;
        status_next[ST_HELD_MSB:ST_HELD_LSB]     = held_w;
        status_next[ST_RSVD_MSB:ST_RSVD_LSB]     = '0;
        status_next[ST_SHORT0_MSB:ST_SHORT0_LSB] = short0_cnt;
        status_next[ST_SHORT1_MSB:ST_SHORT1_LSB] = short1_cnt;
        status_next[ST_LONG_MSB:ST_LONG_LSB]     = long_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            short_press <= '0;
            long_press  <= '0;
            ctrl_start  <= 1'b0;
            ctrl_stop   <= 1'b0;
            ctrl_reset  <= 1'b0;
            short0_cnt  <= '0;
            short1_cnt  <= '0;
            long_cnt    <= '0;
            btn_status  <= '0;
        end else begin
            short_press <= short_evt;
            long_press  <= long_evt;
            ctrl_start  <= short_w[0] & ~transmission_active;
            ctrl_stop   <= short_w[0] & transmission_active;
            ctrl_reset  <= long_w[0];
            short0_cnt  <= short0_cnt + COUNT_W'(short_w[0]);
            short1_cnt  <= short1_cnt + COUNT_W'(short_w[1]);
            long_cnt    <= long_cnt + COUNT_W'(long_w[0]) + COUNT_W'(long_w[1]);
            btn_status  <= status_next;
        end
    end
endmodule

// File: tb/tb_pushbutton_control_decoder.sv
// tb_pushbutton_control_decoder: directed self-checking bench for pushbutton_control_decoder.
module tb_pushbutton_control_decoder;
    logic clk = 1'b0;
    logic rstn;
    logic [1:0] btn;
    logic tx_active;
    logic [1:0] short_press, long_press;
    logic ctrl_start, ctrl_stop, ctrl_reset;
    logic [31:0] btn_status;

    int n_vec = 0, n_err = 0;
    int cyc = 0;
    int n_short0, n_short1, n_long0, n_long1, n_start, n_stop, n_rst, n_ss, n_dual, n_nz;
    int t_short0, t_long0, t_long1, t_start, t_stop, t_rst;

    pushbutton_control_decoder #(
        .NUM_BUTTONS      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .BTN_ACTIVE_LOW   (1'b0)
    ) dut (
        .clk                (clk),
        .rstn               (rstn),
        .btn_raw            (btn),
        .transmission_active(tx_active),
        .short_press        (short_press),
        .long_press         (long_press),
        .ctrl_start         (ctrl_start),
        .ctrl_stop          (ctrl_stop),
        .ctrl_reset         (ctrl_reset),
        .btn_status         (btn_status)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (short_press[0]) begin n_short0++; t_short0 = cyc; end
        if (short_press[1]) n_short1++;
        if (long_press[0]) begin n_long0++; t_long0 = cyc; end
        if (long_press[1]) begin n_long1++; t_long1 = cyc; end
        if (ctrl_start) begin n_start++; t_start = cyc; end
        if (ctrl_stop) begin n_stop++; t_stop = cyc; end
        if (ctrl_reset) begin n_rst++; t_rst = cyc; end
        if (ctrl_start && ctrl_stop) n_ss++;
        if (long_press == 2'b11) n_dual++;
        if (btn_status != 32'd0) n_nz++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr;
        n_short0 = 0; n_short1 = 0; n_long0 = 0; n_long1 = 0; n_start = 0; n_stop = 0;
        n_rst = 0; n_dual = 0; n_nz = 0;
        t_short0 = -1; t_long0 = -1; t_long1 = -1; t_start = -1; t_stop = -1; t_rst = -1;
    endtask

    task automatic test_reset;
        rstn = 1'b0; btn = 2'b00; tx_active = 1'b0;
        step(3);
        n_vec++; if ({short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset} !== 7'd0) begin n_err++; $display("FAIL reset_pulses: got %b want 0", {short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset}); end
        n_vec++; if (btn_status !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h want 0", btn_status); end
        rstn = 1'b1;
        step(1);
        n_vec++; if ({short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset} !== 7'd0) begin n_err++; $display("FAIL post_reset_pulses: got %b want 0", {short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset}); end
        n_vec++; if (btn_status !== 32'd0) begin n_err++; $display("FAIL post_reset_status: got %h want 0", btn_status); end
        step(5);
        n_ss = 0;
    endtask

    task automatic test_bounce;
        clr;
        repeat (5) begin
            btn[0] = 1'b1; step(3);
            btn[0] = 1'b0; step(3);
        end
        step(10);
        n_vec++; if (n_nz !== 0) begin n_err++; $display("FAIL bounce_status: got %0d nonzero cycles want 0", n_nz); end
        n_vec++; if (n_short0 + n_long0 + n_start + n_stop + n_rst !== 0) begin n_err++; $display("FAIL bounce_pulses: got %0d want 0", n_short0 + n_long0 + n_start + n_stop + n_rst); end
    endtask

    task automatic test_short_idle;
        int c0;
        clr; tx_active = 1'b0;
        btn[0] = 1'b1; c0 = cyc;
        step(10);
        btn[0] = 1'b0;
        step(20);
        n_vec++; if (n_short0 !== 1) begin n_err++; $display("FAIL short_idle_count: got %0d want 1", n_short0); end
        n_vec++; if (t_short0 - c0 !== 17) begin n_err++; $display("FAIL short_idle_time: got %0d want 17", t_short0 - c0); end
        n_vec++; if (n_start !== 1 || t_start - c0 !== 17) begin n_err++; $display("FAIL short_idle_start: got n=%0d t=%0d want n=1 t=17", n_start, t_start - c0); end
        n_vec++; if (n_stop + n_rst + n_long0 !== 0) begin n_err++; $display("FAIL short_idle_other: got %0d want 0", n_stop + n_rst + n_long0); end
        n_vec++; if (btn_status !== 32'h0000_0100) begin n_err++; $display("FAIL short_idle_status: got %h want 00000100", btn_status); end
    endtask

    task automatic test_short_tx;
        int c0;
        clr; tx_active = 1'b1;
        btn[0] = 1'b1; c0 = cyc;
        step(10);
        btn[0] = 1'b0;
        step(20);
        tx_active = 1'b0;
        n_vec++; if (n_stop !== 1 || t_stop - c0 !== 17) begin n_err++; $display("FAIL short_tx_stop: got n=%0d t=%0d want n=1 t=17", n_stop, t_stop - c0); end
        n_vec++; if (n_start !== 0) begin n_err++; $display("FAIL short_tx_start: got %0d want 0", n_start); end
        n_vec++; if (btn_status[15:8] !== 8'd2) begin n_err++; $display("FAIL short_tx_count: got %0d want 2", btn_status[15:8]); end
    endtask

    task automatic test_long;
        int c0;
        clr;
        btn[0] = 1'b1; c0 = cyc;
        step(30);
        n_vec++; if (btn_status[3:2] !== 2'b01) begin n_err++; $display("FAIL long_held_flag: got %b want 01", btn_status[3:2]); end
        step(10);
        btn[0] = 1'b0;
        step(20);
        n_vec++; if (n_long0 !== 1 || t_long0 - c0 !== 26) begin n_err++; $display("FAIL long_pulse: got n=%0d t=%0d want n=1 t=26", n_long0, t_long0 - c0); end
        n_vec++; if (n_rst !== 1 || t_rst - c0 !== 26) begin n_err++; $display("FAIL long_ctrl_reset: got n=%0d t=%0d want n=1 t=26", n_rst, t_rst - c0); end
        n_vec++; if (n_short0 + n_start + n_stop !== 0) begin n_err++; $display("FAIL long_no_short: got %0d want 0", n_short0 + n_start + n_stop); end
        n_vec++; if (btn_status !== 32'h0100_0200) begin n_err++; $display("FAIL long_status: got %h want 01000200", btn_status); end
    endtask

    task automatic test_wrap;
        clr;
        repeat (255) begin
            btn[1] = 1'b1; step(10);
            btn[1] = 1'b0; step(10);
        end
        step(10);
        n_vec++; if (btn_status[23:16] !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d want 255", btn_status[23:16]); end
        btn[1] = 1'b1; step(10);
        btn[1] = 1'b0; step(20);
        n_vec++; if (btn_status[23:16] !== 8'd0) begin n_err++; $display("FAIL wrap_0: got %0d want 0", btn_status[23:16]); end
        n_vec++; if (n_short1 !== 256) begin n_err++; $display("FAIL wrap_pulses: got %0d want 256", n_short1); end
        n_vec++; if (n_start + n_stop + n_rst + n_short0 !== 0) begin n_err++; $display("FAIL wrap_no_ctrl: got %0d want 0", n_start + n_stop + n_rst + n_short0); end
        n_vec++; if (btn_status[15:8] !== 8'd2) begin n_err++; $display("FAIL wrap_btn0_count: got %0d want 2", btn_status[15:8]); end
    endtask

    task automatic test_dual_long;
        int c0;
        clr;
        btn = 2'b11; c0 = cyc;
        step(30);
        n_vec++; if (n_dual !== 1) begin n_err++; $display("FAIL dual_together: got %0d want 1", n_dual); end
        n_vec++; if (n_long1 !== 1 || t_long1 - c0 !== 26) begin n_err++; $display("FAIL dual_long1: got n=%0d t=%0d want n=1 t=26", n_long1, t_long1 - c0); end
        n_vec++; if (btn_status[3:0] !== 4'b1111) begin n_err++; $display("FAIL dual_held: got %b want 1111", btn_status[3:0]); end
        btn = 2'b00;
        step(20);
        n_vec++; if (btn_status[31:24] !== 8'd3) begin n_err++; $display("FAIL dual_long_count: got %0d want 3", btn_status[31:24]); end
        n_vec++; if (n_rst !== 1 || n_short0 + n_short1 !== 0) begin n_err++; $display("FAIL dual_ctrl: got rst=%0d short=%0d want 1 0", n_rst, n_short0 + n_short1); end
    endtask

    task automatic test_reset_mid;
        int r0;
        clr;
        btn[0] = 1'b1;
        step(22);
        rstn = 1'b0;
        step(1);
        n_vec++; if ({short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset} !== 7'd0 || btn_status !== 32'd0) begin n_err++; $display("FAIL mid_reset_outputs: got %b/%h want 0/0", {short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset}, btn_status); end
        step(1);
        rstn = 1'b1; r0 = cyc;
        step(1);
        n_vec++; if ({short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset} !== 7'd0 || btn_status !== 32'd0) begin n_err++; $display("FAIL mid_first_cycle: got %b/%h want 0/0", {short_press, long_press, ctrl_start, ctrl_stop, ctrl_reset}, btn_status); end
        step(30);
        n_vec++; if (n_long0 !== 1 || t_long0 - r0 !== 26) begin n_err++; $display("FAIL mid_relong: got n=%0d t=%0d want n=1 t=26", n_long0, t_long0 - r0); end
        n_vec++; if (btn_status !== 32'h0100_0005) begin n_err++; $display("FAIL mid_status: got %h want 01000005", btn_status); end
        btn[0] = 1'b0;
        step(20);
        n_vec++; if (n_short0 + n_start + n_stop !== 0) begin n_err++; $display("FAIL mid_no_short: got %0d want 0", n_short0 + n_start + n_stop); end
        n_vec++; if (n_ss !== 0) begin n_err++; $display("FAIL start_stop_exclusive: got %0d want 0", n_ss); end
    endtask

    initial begin
        test_reset;
        test_bounce;
        test_short_idle;
        test_short_tx;
        test_long;
        test_wrap;
        test_dual_long;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
